// File: rtl/sipo_buf_arbiter_if.sv
// Op handshake between the arbiter (master) and the SIPO buffer controller (slave).
interface sipo_buf_arbiter_if;
  logic buf_val_op;
  logic buf_op;
  logic buf_op_ack;
  logic buf_op_commit;

  modport master (output buf_val_op, buf_op, input buf_op_ack, buf_op_commit);
  modport slave  (input buf_val_op, buf_op, output buf_op_ack, buf_op_commit);
endinterface

// File: rtl/sipo_buf_arbiter.sv
// Round-robin arbiter between the scan-capture writer and host reader in front of the
// 256B SIPO buffer controller; tracks fill level in words and watches for hung commits.
module sipo_buf_arbiter #(
  parameter int DEPTH   = 64,
  parameter int LVLW    = 7,
  parameter int TIMEOUT = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_req,
  output logic                wr_gnt,
  output logic                wr_done,
  input  logic                rd_req,
  output logic                rd_gnt,
  output logic                rd_done,
  sipo_buf_arbiter_if.master  buf_if,
  output logic [LVLW-1:0]     level,
  output logic                full,
  output logic                empty,
  output logic                timeout_err,
  input  logic                clr_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
  logic              wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic              val_op_q, val_op_d, op_q, op_d;
  logic [LVLW-1:0]   level_q, level_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              err_q, err_d;
  logic              last_rd_q, last_rd_d;  // 1: last grant went to the reader
  logic [WDW-1:0]    wd_q, wd_d;
  logic              wr_ok, rd_ok, commit_ev, timeout_ev;

  assign wr_ok = wr_req & ~full_q  & ~err_q;
  assign rd_ok = rd_req & ~empty_q & ~err_q;

  always_comb begin
    state_d    = state_q;
    wr_gnt_d   = 1'b0;
    rd_gnt_d   = 1'b0;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;
    val_op_d   = val_op_q;
    op_d       = op_q;
    level_d    = level_q;
    last_rd_d  = last_rd_q;
    wd_d       = wd_q;
    commit_ev  = 1'b0;
    timeout_ev = 1'b0;

    case (state_q)
      S_IDLE: begin
        val_op_d = 1'b0;
        if (wr_ok && (!rd_ok || last_rd_q)) begin
          state_d  = S_ISSUE;
          op_d     = 1'b0;
          val_op_d = 1'b1;
          wr_gnt_d = 1'b1;
          wd_d     = '0;
        end else if (rd_ok) begin
          state_d  = S_ISSUE;
          op_d     = 1'b1;
          val_op_d = 1'b1;
          rd_gnt_d = 1'b1;
          wd_d     = '0;
        end
      end
      S_ISSUE: begin
        if (buf_if.buf_op_ack && buf_if.buf_op_commit) begin
          commit_ev = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          timeout_ev = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
          if (buf_if.buf_op_ack) begin
            state_d  = S_WAIT;
            val_op_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (buf_if.buf_op_commit) begin
          commit_ev = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          timeout_ev = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit_ev) begin
      state_d  = S_DONE;
      val_op_d = 1'b0;
      if (op_q) begin
        rd_done_d = 1'b1;
        level_d   = level_q - LVLW'(1);
        last_rd_d = 1'b1;
      end else begin
        wr_done_d = 1'b1;
        level_d   = level_q + LVLW'(1);
        last_rd_d = 1'b0;
      end
    end

    // A hung op is abandoned: no done pulse and the level is left alone.
    if (timeout_ev) begin
      state_d  = S_IDLE;
      val_op_d = 1'b0;
    end

    full_d  = (level_d == LVLW'(DEPTH));
    empty_d = (level_d == '0);
    err_d   = clr_err ? 1'b0 : (err_q | timeout_ev);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      val_op_q  <= 1'b0;
      op_q      <= 1'b0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_q     <= 1'b0;
      last_rd_q <= 1'b1;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      val_op_q  <= val_op_d;
      op_q      <= op_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
      last_rd_q <= last_rd_d;
      wd_q      <= wd_d;
    end
  end

  assign wr_gnt            = wr_gnt_q;
  assign rd_gnt            = rd_gnt_q;
  assign wr_done           = wr_done_q;
  assign rd_done           = rd_done_q;
  assign buf_if.buf_val_op = val_op_q;
  assign buf_if.buf_op     = op_q;
  assign level             = level_q;
  assign full              = full_q;
  assign empty             = empty_q;
  assign timeout_err       = err_q;

endmodule

// File: tb/tb_sipo_buf_arbiter.sv
// Directed bench for sipo_buf_arbiter; the bench plays the buffer controller by hand.
module tb_sipo_buf_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req, clr_err;
  logic       wr_gnt, wr_done, rd_gnt, rd_done;
  logic [6:0] level;
  logic       full, empty, timeout_err;
  int         n_checks = 0;
  int         n_fail   = 0;

  sipo_buf_arbiter_if bif ();

  sipo_buf_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .wr_gnt      (wr_gnt),
    .wr_done     (wr_done),
    .rd_req      (rd_req),
    .rd_gnt      (rd_gnt),
    .rd_done     (rd_done),
    .buf_if      (bif),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One op from an IDLE point: request set now, ack in the 2nd ISSUE-side cycle,
  // commit after 'gap' extra WAIT cycles (gap<0: ack and commit together).
  task automatic txn(input bit is_wr, input bit both, input bit keep, input int gap,
                     input int exp_level);
    wr_req = is_wr | both;
    rd_req = ~is_wr | both;
    step();
    chk("gnt", {wr_gnt, rd_gnt}, is_wr ? 2 : 1);
    chk("val_op_issue", bif.buf_val_op, 1);
    chk("op", bif.buf_op, is_wr ? 0 : 1);
    if (!keep) begin
      wr_req = 1'b0;
      rd_req = 1'b0;
    end
    step();
    chk("gnt_one_cycle", {wr_gnt, rd_gnt}, 0);
    chk("val_op_held", bif.buf_val_op, 1);
    bif.buf_op_ack = 1'b1;
    if (gap < 0) begin
      bif.buf_op_commit = 1'b1;
      step();
      bif.buf_op_ack = 1'b0;
      bif.buf_op_commit = 1'b0;
    end else begin
      step();
      bif.buf_op_ack = 1'b0;
      chk("val_op_wait", bif.buf_val_op, 0);
      for (int i = 0; i < gap; i++) begin
        chk("no_early_done", {wr_done, rd_done}, 0);
        step();
      end
      bif.buf_op_commit = 1'b1;
      step();
      bif.buf_op_commit = 1'b0;
    end
    chk("done", {wr_done, rd_done}, is_wr ? 2 : 1);
    chk("level", level, exp_level);
    chk("full", full, exp_level == 64);
    chk("empty", empty, exp_level == 0);
    $display("txn %s gap=%0d level=%0d full=%0b empty=%0b", is_wr ? "wr" : "rd", gap,
             level, full, empty);
    step();
    chk("done_pulse", {wr_done, rd_done}, 0);
  endtask

  initial begin
    reset = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    clr_err = 1'b0;
    bif.buf_op_ack = 1'b0;
    bif.buf_op_commit = 1'b0;
    step();
    step();
    reset = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_outs", {wr_gnt, rd_gnt, wr_done, rd_done, full, timeout_err, bif.buf_val_op}, 0);

    // Read refused while empty.
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_rd_gnt", rd_gnt, 0);
      chk("empty_val_op", bif.buf_val_op, 0);
    end
    chk("empty_flag", empty, 1);
    rd_req = 1'b0;
    $display("txn rd refused while empty");

    // Single write with a 33-cycle shift: ack at t+2, commit at t+35, done at t+36.
    txn(1'b1, 1'b0, 1'b0, 32, 1);

    // Leave last grant on the reader, then tie: wr,rd,wr,rd.
    txn(1'b1, 1'b0, 1'b0, 0, 2);
    txn(1'b0, 1'b0, 1'b0, 0, 1);
    txn(1'b1, 1'b1, 1'b1, 0, 2);
    txn(1'b0, 1'b1, 1'b1, 0, 1);
    txn(1'b1, 1'b1, 1'b1, 0, 2);
    txn(1'b0, 1'b1, 1'b1, 0, 1);
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Fill to DEPTH, then a 65th write is refused.
    for (int n = 2; n <= 64; n++) txn(1'b1, 1'b0, 1'b0, 0, n);
    wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_wr_gnt", wr_gnt, 0);
      chk("full_val_op", bif.buf_val_op, 0);
    end
    wr_req = 1'b0;
    $display("txn wr refused while full level=%0d", level);
    txn(1'b0, 1'b0, 1'b0, 0, 63);

    // Watchdog: ack but never commit; error 63 cycles after ISSUE entry.
    wr_req = 1'b1;
    step();
    chk("wd_gnt", wr_gnt, 1);
    wr_req = 1'b0;
    step();
    bif.buf_op_ack = 1'b1;
    step();
    bif.buf_op_ack = 1'b0;
    for (int i = 3; i < 63; i++) step();
    chk("wd_not_yet", timeout_err, 0);
    step();
    chk("wd_err", timeout_err, 1);
    chk("wd_val_op", bif.buf_val_op, 0);
    chk("wd_no_done", {wr_done, rd_done}, 0);
    chk("wd_level", level, 63);
    $display("txn wr timed out err=%0b level=%0d", timeout_err, level);
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_blocks", {wr_gnt, rd_gnt, wr_done, rd_done}, 0);
    end
    rd_req = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("err_cleared", timeout_err, 0);
    $display("txn clr_err err=%0b", timeout_err);
    // Write after clear; ack and commit arrive together.
    txn(1'b1, 1'b0, 1'b0, -1, 64);

    // Reset during WAIT.
    rd_req = 1'b1;
    step();
    chk("rst6_gnt", rd_gnt, 1);
    rd_req = 1'b0;
    step();
    bif.buf_op_ack = 1'b1;
    step();
    bif.buf_op_ack = 1'b0;
    chk("rst6_in_wait", bif.buf_val_op, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst6_level", level, 0);
    chk("rst6_empty", empty, 1);
    chk("rst6_outs", {wr_gnt, rd_gnt, wr_done, rd_done, full, timeout_err, bif.buf_val_op}, 0);
    bif.buf_op_commit = 1'b1;
    step();
    bif.buf_op_commit = 1'b0;
    chk("rst6_no_done", {wr_done, rd_done}, 0);
    $display("txn reset during WAIT level=%0d empty=%0b", level, empty);

    // After reset the writer wins the first grant.
    txn(1'b1, 1'b0, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
